// File: rtl/bitwise_accum_pkg.sv
// Shared types for the bitwise frame accumulator: operation codes and FSM states.
package bitwise_accum_pkg;

    // Encodings match the op_i port values.
    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    // NAND accumulates as AND; only the presented result is inverted.
    function automatic logic op_inverts_result(input op_t op);
        return op == OP_NAND;
    endfunction

endpackage

// File: rtl/bitwise_alu.sv
// Combinational accumulate step: y = a OP b, with NAND treated as AND.
module bitwise_alu
    import bitwise_accum_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    // Select the bitwise reduction step for the latched operation.
    always_comb begin
        y = '0;
        unique case (op)
            OP_AND, OP_NAND: y = a & b;
            OP_OR:           y = a | b;
            OP_XOR:          y = a ^ b;
            default:         y = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_accum.sv
// Frame-based bitwise reduction: folds a stream of words with AND/OR/XOR/NAND,
// counts the words (saturating, with sticky overflow) and holds the result
// until the consumer takes it.
module bitwise_accum
    import bitwise_accum_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       op_i,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    output logic [$clog2(MAX_LEN+1)-1:0]     out_count,
    output logic                             out_overflow
);

    localparam int unsigned CntW = $clog2(MAX_LEN + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_LEN);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;

    logic [WIDTH-1:0]  alu_y;
    logic              accept;
    op_t               op_in;

    assign op_in  = op_t'(op_i);
    // in_ready is decoded from state only, so there is no input-to-output path.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;

    assign out_data     = out_data_q;
    assign out_count    = count_q;
    assign out_overflow = ovf_q;

    bitwise_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a  (acc_q),
        .b  (in_data),
        .op (op_q),
        .y  (alu_y)
    );

    // Next-state logic: frame start, accumulate, close frame, hand off result.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;

        unique case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    if (state_q == IDLE) begin
                        // First word seeds the accumulator and fixes the op for the frame.
                        acc_d   = in_data;
                        count_d = CntOne;
                        op_d    = op_in;
                        ovf_d   = 1'b0;
                    end else begin
                        acc_d = alu_y;
                        if (count_q == CntMax) begin
                            ovf_d = 1'b1;
                        end else begin
                            count_d = count_q + CntOne;
                        end
                    end

                    if (in_last) begin
                        state_d    = HOLD;
                        out_data_d = op_inverts_result(op_d) ? ~acc_d : acc_d;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial or pending frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_AND;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_bitwise_accum.sv
// Self-checking bench for bitwise_accum: directed frames with literal
// expectations plus randomized frames checked against a frame-level model.
module tb_bitwise_accum;

    localparam int W  = 8;
    localparam int ML = 4;
    localparam int CW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    op_i;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_overflow;

    int errors = 0;
    int checks = 0;

    bitwise_accum #(
        .WIDTH   (W),
        .MAX_LEN (ML)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_i         (op_i),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_count    (out_count),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: reduce the whole frame at once from the op of its first word.
    function automatic logic [W-1:0] reduce(input logic [1:0] op, input logic [W-1:0] w[$]);
        logic [W-1:0] r;
        r = w[0];
        for (int i = 1; i < w.size(); i++) begin
            case (op)
                2'd1:    r = r | w[i];
                2'd2:    r = r ^ w[i];
                default: r = r & w[i];
            endcase
        end
        if (op == 2'd3) r = ~r;
        return r;
    endfunction

    // Frame-level model state.
    bit           m_hold = 1'b0;
    logic [W-1:0] words[$];
    logic [1:0]   m_op = 2'd0;
    logic [W-1:0] e_data = '0;
    int           e_cnt = 0;
    bit           e_ovf = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_hold = 1'b0;
                words.delete();
            end else if (m_hold) begin
                if (out_ready) m_hold = 1'b0;
            end else if (in_valid) begin
                if (words.size() == 0) m_op = op_i;
                words.push_back(in_data);
                if (in_last) begin
                    e_data = reduce(m_op, words);
                    e_cnt  = (words.size() > ML) ? ML : words.size();
                    e_ovf  = (words.size() > ML);
                    m_hold = 1'b1;
                    words.delete();
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd1);
                chk("rst_out_data", 32'(out_data), 32'd0);
                chk("rst_out_count", 32'(out_count), 32'd0);
                chk("rst_out_overflow", 32'(out_overflow), 32'd0);
            end else begin
                chk("model_in_ready", 32'(in_ready), 32'(!m_hold));
                chk("model_out_valid", 32'(out_valid), 32'(m_hold));
                if (m_hold) begin
                    chk("model_out_data", 32'(out_data), 32'(e_data));
                    chk("model_out_count", 32'(out_count), 32'(e_cnt));
                    chk("model_out_overflow", 32'(out_overflow), 32'(e_ovf));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] d, input logic last);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1 at %0t", $time);
        end
        op_i     = op;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [W-1:0] d, input int cnt,
                                 input logic ovf);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out_data"}, 32'(out_data), 32'(d));
        chk({tag, "_out_count"}, 32'(out_count), 32'(cnt));
        chk({tag, "_out_overflow"}, 32'(out_overflow), 32'(ovf));
    endtask

    initial begin
        rst       = 1'b1;
        op_i      = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        rst = 1'b0;
        tick();

        // AND frame.
        send(2'd0, 8'hF0, 1'b0);
        send(2'd0, 8'h3C, 1'b0);
        send(2'd0, 8'hFF, 1'b1);
        expect_result("and3", 8'h30, 3, 1'b0);
        consume();
        chk("and3_release_valid", 32'(out_valid), 32'd0);

        // OR single word: result visible right after the accepting edge.
        send(2'd1, 8'hA5, 1'b1);
        expect_result("or1", 8'hA5, 1, 1'b0);
        consume();

        // XOR with back-pressure.
        send(2'd2, 8'h0F, 1'b0);
        send(2'd2, 8'hFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("xor_hold_data", 32'(out_data), 32'h0F0);
            chk("xor_hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("xor_release_valid", 32'(out_valid), 32'd0);
        chk("xor_release_in_ready", 32'(in_ready), 32'd1);

        // NAND with op change mid-frame (ignored).
        send(2'd3, 8'hFF, 1'b0);
        send(2'd1, 8'h0F, 1'b1);
        expect_result("nand2", 8'hF0, 2, 1'b0);
        consume();

        // Six-word OR frame overflows MAX_LEN=4.
        for (int i = 0; i < 6; i++) send(2'd1, 8'(1 << i), 1'(i == 5));
        expect_result("ovf6", 8'h3F, 4, 1'b1);
        consume();
        send(2'd0, 8'h77, 1'b1);
        expect_result("after_ovf", 8'h77, 1, 1'b0);
        consume();

        // Reset mid-frame discards the partial frame.
        send(2'd1, 8'h12, 1'b0);
        send(2'd1, 8'h34, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_count", 32'(out_count), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        send(2'd0, 8'h55, 1'b1);
        expect_result("post_rst", 8'h55, 1, 1'b0);
        consume();

        // Randomized frames; the per-cycle compare does the checking.
        for (int f = 0; f < 150; f++) begin
            int len;
            int k;
            if ($urandom_range(0, 19) == 0) begin
                send(2'($urandom), 8'($urandom), 1'b0);
                rst = 1'b1;
                tick();
                rst = 1'b0;
                tick();
            end
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send(2'($urandom), 8'($urandom), 1'(i == len - 1));
            end
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                in_valid = 1'($urandom);
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                op_i     = 2'($urandom);
                tick();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            consume();
        end

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bitwise_accum.md
BITWISE_ACCUM -- requirements
Module: bitwise_accum

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: WIDTH, default 8, data word width in bits.
REQ-003 Parameter: MAX_LEN, default 16, maximum words counted per frame.
REQ-004 Ports (name, direction, width, meaning):
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 op_i  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-008 in_valid  in  1  input word valid.
REQ-009 in_ready  out  1  block accepts input word.
REQ-010 in_data  in  WIDTH  input word.
REQ-011 in_last  in  1  accepted word closes the frame.
REQ-012 out_valid  out  1  frame result valid.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_data  out  WIDTH  frame reduction result.
REQ-015 out_count  out  $clog2(MAX_LEN+1)  words counted in the frame.
REQ-016 out_overflow  out  1  frame exceeded MAX_LEN words.

Function
REQ-017 A word SHALL be accepted on a rising clk edge where in_valid and in_ready are both 1.
REQ-018 The FSM SHALL have the states IDLE, ACCUM and HOLD.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; in_ready SHALL depend on state only.
REQ-020 On an accept in IDLE, the block SHALL set acc=in_data and count=1, latch op_i, and clear overflow.
REQ-021 On an accept in ACCUM, the block SHALL update acc = acc OP in_data (NAND accumulates as AND).
REQ-022 op_i changes after the first word of a frame SHALL be ignored until the next frame.
REQ-023 count SHALL increment per accepted word and saturate at MAX_LEN.
REQ-024 An accept while count==MAX_LEN SHALL set out_overflow (sticky until the next frame).
REQ-025 An accept with in_last=1 (IDLE or ACCUM) SHALL move the FSM to HOLD.
REQ-026 An accept with in_last=0 SHALL move the FSM to or keep it in ACCUM.
REQ-027 In HOLD, out_valid SHALL be 1 and out_data SHALL be acc, inverted when the latched op is NAND.
REQ-028 out_valid SHALL rise exactly one cycle after the in_last accept (latency 1).
REQ-029 out_data, out_count and out_overflow SHALL remain stable while out_valid=1 and out_ready=0.
REQ-030 out_valid and out_ready both 1 SHALL return the FSM to IDLE, with out_valid=0 on the next cycle.
REQ-031 A single-word frame SHALL produce out_data=in_data (inverted for NAND) and out_count=1.
REQ-032 There SHALL be no combinational path from any input to any output; all outputs SHALL be registered or decoded from state.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, acc=0, count=0, out_valid=0, out_data=0, out_count=0 and out_overflow=0 (in_ready=1).
REQ-034 Reset mid-frame or in HOLD SHALL discard the partial or pending result; the first accept after reset SHALL start a fresh frame.

Structure
REQ-035 A shared package SHALL hold the op_t enum (OP_AND, OP_OR, OP_XOR, OP_NAND) and the state_t enum (IDLE, ACCUM, HOLD).
REQ-036 One combinational sub-module, bitwise_alu (WIDTH-parametrised, a/b/op -> y), SHALL compute the accumulate step.

Verification (WIDTH=8)
REQ-037 AND frame 0xF0, 0x3C, 0xFF(last) -> out_data=0x30, out_count=3, out_overflow=0.
REQ-038 OR single word 0xA5 with last=1 -> out_valid=1 on the next cycle, out_data=0xA5, out_count=1.
REQ-039 XOR frame 0x0F, 0xFF(last) with out_ready held 0 for 5 cycles -> out_data=0xF0 stable, in_ready=0 throughout; one cycle after out_ready=1, out_valid=0 and in_ready=1.
REQ-040 NAND frame 0xFF, 0x0F(last), with op_i switched to OR after the first word -> out_data=0xF0.
REQ-041 MAX_LEN=4, six-word OR frame -> out_count=4, out_overflow=1; the next frame clears out_overflow.
REQ-042 rst asserted after 2 of 4 words -> all outputs 0 immediately; new frame 0x55(last) with AND -> out_data=0x55, out_count=1.
